bus_matrix_axi_wr_sched: RTL and testbench
==========================================

# bus_matrix_axi_wr_sched

Per-slave-port write-transaction scheduler for the AXI4-Lite bus matrix. It arbitrates round-robin among masters requesting one slave port. It holds the grant across the full AW/W/B transaction, and it gates the AW and W valids so each phase is accepted exactly once, in either order. An optional watchdog terminates a hung transaction with a locally generated SLVERR. The matrix instantiates one per slave port and uses `gnt_o` to steer its AW/W/B muxes.

## Interface
- `N_MASTERS`, 2, number of requesting masters (≥1)
- `TIMEOUT_CYCLES`, 256, watchdog limit in aclk cycles (≥2)
- `CNT_WIDTH`, `$clog2(TIMEOUT_CYCLES+1)`, watchdog counter width
- `aclk` input 1: clock
- `aresetn` input 1: reset, asynchronous, active-low
- `req_i` input N_MASTERS: per master, `awvalid` AND decoder-select for this slave
- `gnt_o` output N_MASTERS: one-hot (or zero) grant, registered
- `busy_o` output 1: state != IDLE
- `s_awvalid_i`, `s_awready_i` input 1 each: muxed AW valid (before gating) and slave AW ready
- `s_wvalid_i`, `s_wready_i` input 1 each: muxed W valid and slave W ready
- `s_bvalid_i` input 1: slave B valid
- `gnt_bready_i` input 1: bready of the granted master
- `aw_en_o` output 1: matrix drives slave `awvalid = s_awvalid_i & aw_en_o`
- `w_en_o` output 1: matrix drives slave `wvalid = s_wvalid_i & w_en_o`
- `b_err_o` output 1: matrix drives granted master `bvalid=1`, `bresp=SLVERR`, and forces slave `bready=0`
- `timeout_o` output 1: one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, ADDR_DATA, RESP, ERR_RESP.
- **IDLE:**
  - If `req_i != 0`, pick the first set bit scanning from `(last+1) mod N_MASTERS` upward with wrap.
  - Register `gnt_o`, set `last` = picked index, go to ADDR_DATA.
  - `aw_done` and `w_done` are cleared.
- **ADDR_DATA:**
  - `aw_en_o = !aw_done`; `w_en_o = !w_done`.
  - AW handshake (`s_awvalid_i & aw_en_o & s_awready_i`) sets `aw_done`; the W handshake sets `w_done`.
  - When both are done, including same-cycle completion of the last one, go to RESP.
- **RESP:**
  - `aw_en_o = w_en_o = 0`.
  - On `s_bvalid_i & gnt_bready_i`, go to IDLE and clear `gnt_o` on the same edge.
- **ERR_RESP:**
  - `b_err_o = 1`, and both enables are 0.
  - On `gnt_bready_i`, go to IDLE and clear `gnt_o`.
  - A late slave B is never routed, because slave bready is held 0.
- **Watchdog:**
  - Counter clears on entry to ADDR_DATA and on every AW/W handshake.
  - It increments each cycle in ADDR_DATA or RESP.
  - When it reaches `TIMEOUT_CYCLES - 1`, the next edge enters ERR_RESP and `timeout_o` pulses for that cycle.
  - A B handshake on that same cycle takes priority: go to IDLE with no timeout.
- `req_i` changes while the block is busy are ignored. `gnt_o` is constant from grant until return to IDLE.
- `last` resets to `N_MASTERS-1`, so master 0 wins the first arbitration.

## Timing
- Reset values:
  - `gnt_o = 0`, `busy_o = 0`, `aw_en_o = 0`, `w_en_o = 0`, `b_err_o = 0`, `timeout_o = 0`.
  - State IDLE, counter 0.
- Grant latency: 1 cycle from `req_i` to `gnt_o`.
- AW/W gates are combinational from state and flags. There is no combinational path from `s_*ready` to `aw_en_o`/`w_en_o`.
- Back-to-back throughput: at minimum one IDLE cycle between transactions (B handshake edge → IDLE → grant edge).
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). The in-flight transaction is abandoned.

## Configuration
- `BUS_MATRIX_WR_WDOG_EN` defined: watchdog counter, ERR_RESP state and `timeout_o` are present.
- Not defined:
  - No counter is built and ERR_RESP is unreachable.
  - `b_err_o` and `timeout_o` are tied 0.
  - A hung slave holds the grant indefinitely.

## Structure
- `bus_matrix_pkg` additions:
  - `wr_sched_state_t` enum (IDLE, ADDR_DATA, RESP, ERR_RESP).
  - `AXI_RESP_OKAY = 2'b00`, `AXI_RESP_SLVERR = 2'b10`.
- Sub-module `bus_matrix_wr_wdog`:
  - Parameterised counter with `clear`, `enable` and `expire` outputs.
  - Instantiated only under `BUS_MATRIX_WR_WDOG_EN`.
- Round-robin pick stays inline as a combinational function.

## Test plan
- **Single write, AW before W:**
  - Stimulus: `req_i=01`; AW accepted cycle 2, W cycle 4, B cycle 6.
  - Response: `gnt_o=01` from cycle 1 to the cycle-6 edge; `aw_en_o` low from cycle 3; IDLE after cycle 6.
- **W before AW, and same-cycle AW+W:**
  - Response in both cases: each phase handshakes exactly once; RESP is entered the cycle after the second handshake.
- **Contention:**
  - Stimulus: `req_i=11` held for 4 transactions.
  - Response: grants alternate 01, 10, 01, 10, with one IDLE cycle between each.
- **Watchdog** (macro on, `TIMEOUT_CYCLES=8`):
  - Stimulus: AW+W accepted, slave never asserts bvalid.
  - Response: `timeout_o` pulses 8 cycles after the last handshake; `b_err_o=1` until `gnt_bready_i`; a later slave bvalid is ignored.
- **Reset mid-RESP:**
  - Stimulus: `aresetn` low during RESP.
  - Response: outputs zero immediately; after release, `req_i=10` is granted to master 1 and `req_i=11` to master 0.
- **Macro off:**
  - Stimulus: the same hung slave.
  - Response: grant held for more than 1000 cycles; `b_err_o` and `timeout_o` never asserted.

Source files
------------

// File: rtl/bus_matrix_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_matrix_pkg : shared types and constants for the AXI4-Lite bus matrix
// Revision: 1.0
// ----------------------------------------------------------------------------
package bus_matrix_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ADDR_DATA = 2'd1,
      RESP      = 2'd2,
      ERR_RESP  = 2'd3
   } wr_sched_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/bus_matrix_wr_wdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_matrix_wr_wdog : write-transaction watchdog counter, flags expiry at LIMIT-1
// Revision: 1.0
// ----------------------------------------------------------------------------
module bus_matrix_wr_wdog #(
   parameter int LIMIT = 256,
   parameter int WIDTH = $clog2(LIMIT + 1)
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (count == WIDTH'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/bus_matrix_axi_wr_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_matrix_axi_wr_sched : per-slave round-robin AW/W/B write scheduler.
// Optional watchdog under BUS_MATRIX_WR_WDOG_EN.  Revision: 1.0
// ----------------------------------------------------------------------------
module bus_matrix_axi_wr_sched
   import bus_matrix_pkg::*;
#(
   parameter int N_MASTERS      = 2,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [N_MASTERS-1:0] req_i,
   output logic [N_MASTERS-1:0] gnt_o,
   output logic                 busy_o,
   input  logic                 s_awvalid_i,
   input  logic                 s_awready_i,
   input  logic                 s_wvalid_i,
   input  logic                 s_wready_i,
   input  logic                 s_bvalid_i,
   input  logic                 gnt_bready_i,
   output logic                 aw_en_o,
   output logic                 w_en_o,
   output logic                 b_err_o,
   output logic                 timeout_o
);

   localparam int LAST_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   wr_sched_state_t      state, state_d;
   logic [N_MASTERS-1:0] gnt, gnt_d;
   logic [LAST_W-1:0]    last, last_d, pick;
   logic                 aw_done, aw_done_d, w_done, w_done_d;
   logic                 aw_en, w_en, b_err, aw_hs, w_hs;
   logic                 wd_clear, wd_enable, expire, timeout_d;

   // Scan from prev+1 upward with wrap; smallest offset wins.
   function automatic logic [LAST_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                  input logic [LAST_W-1:0]    prev);
      int idx;
      rr_pick = prev;
      for (int i = N_MASTERS; i >= 1; i--) begin
         idx = (int'(prev) + i) % N_MASTERS;
         if (req[idx]) rr_pick = LAST_W'(idx);
      end
   endfunction

   assign pick = rr_pick(req_i, last);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= IDLE;
         gnt     <= '0;
         last    <= LAST_W'(N_MASTERS - 1);
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_d;
         gnt     <= gnt_d;
         last    <= last_d;
         aw_done <= aw_done_d;
         w_done  <= w_done_d;
      end
   end

   always_comb begin
      state_d   = state;
      gnt_d     = gnt;
      last_d    = last;
      aw_done_d = aw_done;
      w_done_d  = w_done;
      aw_en     = 1'b0;
      w_en      = 1'b0;
      b_err     = 1'b0;
      aw_hs     = 1'b0;
      w_hs      = 1'b0;
      wd_clear  = 1'b0;
      wd_enable = 1'b0;
      timeout_d = 1'b0;
      case (state)
         IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (|req_i) begin
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               last_d      = pick;
               wd_clear    = 1'b1;
               state_d     = ADDR_DATA;
            end
         end
         ADDR_DATA: begin
            aw_en     = !aw_done;
            w_en      = !w_done;
            aw_hs     = s_awvalid_i & aw_en & s_awready_i;
            w_hs      = s_wvalid_i & w_en & s_wready_i;
            aw_done_d = aw_done | aw_hs;
            w_done_d  = w_done | w_hs;
            wd_enable = 1'b1;
            wd_clear  = aw_hs | w_hs;
            if (aw_done_d && w_done_d) state_d = RESP;
            if (expire) begin
               state_d   = ERR_RESP;
               timeout_d = 1'b1;
            end
         end
         RESP: begin
            wd_enable = 1'b1;
            if (s_bvalid_i && gnt_bready_i) begin
               state_d = IDLE;
               gnt_d   = '0;
            end else if (expire) begin
               state_d   = ERR_RESP;
               timeout_d = 1'b1;
            end
         end
         ERR_RESP: begin
`ifdef BUS_MATRIX_WR_WDOG_EN
            // Slave bready stays low here, so a late slave B never reaches the master.
            b_err = 1'b1;
            if (gnt_bready_i) begin
               state_d = IDLE;
               gnt_d   = '0;
            end
`else
            state_d = IDLE;
            gnt_d   = '0;
`endif
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

`ifdef BUS_MATRIX_WR_WDOG_EN
   logic timeout_q;

   bus_matrix_wr_wdog #(
      .LIMIT (TIMEOUT_CYCLES),
      .WIDTH (CNT_WIDTH)
   ) u_wdog (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expire  (expire)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) timeout_q <= 1'b0;
      else          timeout_q <= timeout_d;
   end

   assign timeout_o = timeout_q;
`else
   logic unused_wdog;

   assign expire      = 1'b0;
   assign timeout_o   = 1'b0;
   assign unused_wdog = ^{wd_clear, wd_enable, timeout_d,
                          (TIMEOUT_CYCLES > 1), (CNT_WIDTH > 0)};
`endif

   assign gnt_o   = gnt;
   assign busy_o  = (state != IDLE);
   assign aw_en_o = aw_en;
   assign w_en_o  = w_en;
   assign b_err_o = b_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_matrix_axi_wr_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bus_matrix_axi_wr_sched : scoreboard bench for the write scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_bus_matrix_axi_wr_sched;

   logic       aclk = 1'b0;
   logic       aresetn;
   logic [1:0] req;
   logic       awv, awr, wv, wr, bv, bready;
   logic [1:0] gnt;
   logic       busy, aw_en, w_en, b_err, timeout;

   int         tests = 0;
   int         fails = 0;
   int         aw_cnt = 0;
   int         w_cnt = 0;
   logic [1:0] exp_q[$];
   logic [1:0] prev_gnt = 2'b00;

   bus_matrix_axi_wr_sched #(
      .N_MASTERS      (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .req_i        (req),
      .gnt_o        (gnt),
      .busy_o       (busy),
      .s_awvalid_i  (awv),
      .s_awready_i  (awr),
      .s_wvalid_i   (wv),
      .s_wready_i   (wr),
      .s_bvalid_i   (bv),
      .gnt_bready_i (bready),
      .aw_en_o      (aw_en),
      .w_en_o       (w_en),
      .b_err_o      (b_err),
      .timeout_o    (timeout)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not complete, failed=%0d", fails);
      $fatal(1, "bench time limit expired");
   end

   // Samples after the negedge drive settles: values here are those the next posedge sees.
   initial begin : monitor
      logic [1:0] e;
      forever begin
         @(negedge aclk);
         #2;
         if (!aresetn) begin
            prev_gnt = 2'b00;
         end else begin
            if (awv && aw_en && awr) aw_cnt++;
            if (wv && w_en && wr) w_cnt++;
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL grant_order: got %b, expected no grant", gnt);
               end else begin
                  e = exp_q.pop_front();
                  if (gnt !== e) begin
                     fails++;
                     $display("FAIL grant_order: got %b, expected %b", gnt, e);
                  end
               end
            end else if (prev_gnt != 2'b00 && gnt != 2'b00) begin
               tests++;
               if (gnt !== prev_gnt) begin
                  fails++;
                  $display("FAIL grant_stable: got %b, expected %b", gnt, prev_gnt);
               end
            end
            prev_gnt = gnt;
         end
      end
   end

   task automatic drive_idle;
      req = 2'b00; awv = 1'b0; awr = 1'b0; wv = 1'b0; wr = 1'b0; bv = 1'b0; bready = 1'b0;
   endtask

   task automatic set_hs(input logic v);
      awv = v; awr = v; wv = v; wr = v;
   endtask

   task automatic test_reset;
      aresetn = 1'b0;
      drive_idle();
      repeat (3) @(negedge aclk);
      tests++;
      if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b, expected 00", gnt); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      tests++;
      if ({aw_en, w_en} !== 2'b00) begin fails++; $display("FAIL reset_gates: got %b, expected 00", {aw_en, w_en}); end
      tests++;
      if ({b_err, timeout} !== 2'b00) begin fails++; $display("FAIL reset_err: got %b, expected 00", {b_err, timeout}); end
      aresetn = 1'b1;
      @(negedge aclk);
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL idle_no_req: busy got %b, expected 0", busy); end
   endtask

   task automatic test_contention;
      logic [1:0] want;
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      req = 2'b11;
      for (int t = 0; t < 4; t++) begin
         want = (t % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge aclk);
         tests++;
         if ({busy, gnt} !== {1'b1, want}) begin
            fails++; $display("FAIL contention_grant %0d: got %b, expected %b", t, {busy, gnt}, {1'b1, want});
         end
         set_hs(1'b1);
         @(negedge aclk);
         set_hs(1'b0);
         bv = 1'b1; bready = 1'b1;
         if (t == 3) req = 2'b00;
         tests++;
         if ({busy, aw_en, w_en} !== 3'b100) begin
            fails++; $display("FAIL contention_resp %0d: got %b, expected 100", t, {busy, aw_en, w_en});
         end
         @(negedge aclk);
         bv = 1'b0; bready = 1'b0;
         tests++;
         if ({busy, gnt} !== 3'b000) begin
            fails++; $display("FAIL contention_idle_gap %0d: got %b, expected 000", t, {busy, gnt});
         end
      end
   endtask

   task automatic test_reset_mid_resp;
      req = 2'b01; exp_q.push_back(2'b01);
      @(negedge aclk);
      req = 2'b00; set_hs(1'b1);
      @(negedge aclk);
      set_hs(1'b0);
      tests++;
      if ({busy, aw_en, w_en} !== 3'b100) begin fails++; $display("FAIL rst_pre_resp: got %b, expected 100", {busy, aw_en, w_en}); end
      aresetn = 1'b0;
      #1;
      tests++;
      if ({gnt, busy, aw_en, w_en, b_err, timeout} !== 7'b0) begin
         fails++; $display("FAIL reset_async: got %b, expected 0000000", {gnt, busy, aw_en, w_en, b_err, timeout});
      end
      @(negedge aclk);
      aresetn = 1'b1;
      req = 2'b10; exp_q.push_back(2'b10);
      @(negedge aclk);
      tests++;
      if (gnt !== 2'b10) begin fails++; $display("FAIL rst_first_grant: got %b, expected 10", gnt); end
      req = 2'b00; set_hs(1'b1);
      @(negedge aclk);
      set_hs(1'b0); bv = 1'b1; bready = 1'b1;
      @(negedge aclk);
      bv = 1'b0; bready = 1'b0;
      req = 2'b11; exp_q.push_back(2'b01);
      @(negedge aclk);
      tests++;
      if (gnt !== 2'b01) begin fails++; $display("FAIL rst_rr_grant: got %b, expected 01", gnt); end
      req = 2'b00; set_hs(1'b1);
      @(negedge aclk);
      set_hs(1'b0); bv = 1'b1; bready = 1'b1;
      @(negedge aclk);
      drive_idle();
   endtask

   task automatic test_aw_then_w;
      aw_cnt = 0; w_cnt = 0;
      req = 2'b01; exp_q.push_back(2'b01);
      @(negedge aclk);
      tests++;
      if ({busy, gnt, aw_en, w_en} !== 5'b10111) begin
         fails++; $display("FAIL single_grant: got %b, expected 10111", {busy, gnt, aw_en, w_en});
      end
      req = 2'b00; awv = 1'b1; awr = 1'b1;
      @(negedge aclk);
      tests++;
      if ({aw_en, w_en} !== 2'b01) begin fails++; $display("FAIL aw_gate_closed: got %b, expected 01", {aw_en, w_en}); end
      @(negedge aclk);
      tests++;
      if ({aw_en, w_en, gnt} !== 4'b0101) begin fails++; $display("FAIL aw_wait_w: got %b, expected 0101", {aw_en, w_en, gnt}); end
      wv = 1'b1; wr = 1'b1;
      @(negedge aclk);
      tests++;
      if ({aw_en, w_en, busy, gnt} !== 5'b00101) begin
         fails++; $display("FAIL single_resp: got %b, expected 00101", {aw_en, w_en, busy, gnt});
      end
      bv = 1'b1; bready = 1'b0;
      @(negedge aclk);
      tests++;
      if ({busy, gnt} !== 3'b101) begin fails++; $display("FAIL b_needs_bready: got %b, expected 101", {busy, gnt}); end
      bready = 1'b1;
      @(negedge aclk);
      tests++;
      if ({busy, gnt} !== 3'b000) begin fails++; $display("FAIL single_done: got %b, expected 000", {busy, gnt}); end
      drive_idle();
      tests++;
      if (aw_cnt !== 1 || w_cnt !== 1) begin fails++; $display("FAIL single_hs_count: aw=%0d w=%0d, expected 1 1", aw_cnt, w_cnt); end
   endtask

   task automatic test_w_then_aw;
      aw_cnt = 0; w_cnt = 0;
      req = 2'b01; exp_q.push_back(2'b01);
      @(negedge aclk);
      req = 2'b00; wv = 1'b1; wr = 1'b1;
      @(negedge aclk);
      tests++;
      if ({aw_en, w_en} !== 2'b10) begin fails++; $display("FAIL w_gate_closed: got %b, expected 10", {aw_en, w_en}); end
      awv = 1'b1; awr = 1'b1;
      @(negedge aclk);
      tests++;
      if ({aw_en, w_en, busy} !== 3'b001) begin fails++; $display("FAIL w_first_resp: got %b, expected 001", {aw_en, w_en, busy}); end
      bv = 1'b1; bready = 1'b1;
      @(negedge aclk);
      drive_idle();
      tests++;
      if (aw_cnt !== 1 || w_cnt !== 1 || busy !== 1'b0) begin
         fails++; $display("FAIL w_first_count: aw=%0d w=%0d busy=%b, expected 1 1 0", aw_cnt, w_cnt, busy);
      end
   endtask

   task automatic test_same_cycle;
      aw_cnt = 0; w_cnt = 0;
      req = 2'b01; exp_q.push_back(2'b01);
      @(negedge aclk);
      req = 2'b00; set_hs(1'b1);
      @(negedge aclk);
      tests++;
      if ({aw_en, w_en, busy, gnt} !== 5'b00101) begin
         fails++; $display("FAIL same_cycle_resp: got %b, expected 00101", {aw_en, w_en, busy, gnt});
      end
      bv = 1'b1; bready = 1'b1;
      @(negedge aclk);
      drive_idle();
      tests++;
      if (aw_cnt !== 1 || w_cnt !== 1 || busy !== 1'b0) begin
         fails++; $display("FAIL same_cycle_count: aw=%0d w=%0d busy=%b, expected 1 1 0", aw_cnt, w_cnt, busy);
      end
   endtask

`ifdef BUS_MATRIX_WR_WDOG_EN
   task automatic test_watchdog;
      int t_first, e_first, pulses;
      t_first = -1; e_first = -1; pulses = 0;
      req = 2'b01; exp_q.push_back(2'b01);
      @(negedge aclk);
      req = 2'b00; set_hs(1'b1);
      for (int k = 1; k <= 12; k++) begin
         @(negedge aclk);
         set_hs(1'b0);
         if (timeout === 1'b1) begin
            pulses++;
            if (t_first < 0) t_first = k;
         end
         if (b_err === 1'b1 && e_first < 0) e_first = k;
      end
      tests++;
      if (t_first !== 9 || pulses !== 1) begin
         fails++; $display("FAIL wdog_pulse: first=%0d pulses=%0d, expected 9 1", t_first, pulses);
      end
      tests++;
      if (e_first !== 9) begin fails++; $display("FAIL wdog_err_start: got %0d, expected 9", e_first); end
      bv = 1'b1; bready = 1'b0;
      repeat (3) @(negedge aclk);
      tests++;
      if ({b_err, busy, aw_en, w_en, gnt} !== 6'b110001) begin
         fails++; $display("FAIL wdog_err_hold: got %b, expected 110001", {b_err, busy, aw_en, w_en, gnt});
      end
      bv = 1'b0; bready = 1'b1;
      @(negedge aclk);
      drive_idle();
      tests++;
      if ({b_err, busy, gnt} !== 4'b0000) begin fails++; $display("FAIL wdog_release: got %b, expected 0000", {b_err, busy, gnt}); end
   endtask
`else
   task automatic test_hung_no_wdog;
      int bad;
      bad = 0;
      req = 2'b01; exp_q.push_back(2'b01);
      @(negedge aclk);
      req = 2'b00; set_hs(1'b1);
      for (int k = 0; k < 1100; k++) begin
         @(negedge aclk);
         set_hs(1'b0);
         if (gnt !== 2'b01 || busy !== 1'b1 || b_err !== 1'b0 || timeout !== 1'b0) bad++;
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL hung_hold: bad cycles got %0d, expected 0", bad); end
      bv = 1'b1; bready = 1'b1;
      @(negedge aclk);
      drive_idle();
      tests++;
      if ({busy, gnt} !== 3'b000) begin fails++; $display("FAIL hung_release: got %b, expected 000", {busy, gnt}); end
   endtask
`endif

   initial begin
      test_reset();
      test_contention();
      test_reset_mid_resp();
      test_aw_then_w();
      test_w_then_aw();
      test_same_cycle();
`ifdef BUS_MATRIX_WR_WDOG_EN
      test_watchdog();
`else
      test_hung_no_wdog();
`endif
      repeat (2) @(negedge aclk);
      tests++;
      if (exp_q.size() !== 0) begin fails++; $display("FAIL sb_leftover: got %0d queued, expected 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
